// File: rtl/ddr3_pixel_reader.sv
// Reads one frame from DDR3 as Avalon bursts and streams it out as pixels through a word FIFO and lane unpacker.
// Optional macro DDR3_READER_LOOP_EN: wrap to the frame base after the last burst and keep reading without start.
module ddr3_pixel_reader #(
    parameter int          out_width     = 16,
    parameter int          burst_len     = 8,
    parameter int          num_pixels    = 2764800,
    parameter int          fifo_depth    = 32,
    parameter logic [31:0] start_address = 32'h36000000
) (
    input  logic                          ddr3_clk,
    input  logic                          ddr3_clk_reset_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          frame_done,
    output logic [26:0]                   ddr3_read_address,
    output logic                          ddr3_read,
    output logic [7:0]                    ddr3_burstcount,
    input  logic                          ddr3_waitrequest,
    input  logic [255:0]                  ddr3_readdata,
    input  logic                          ddr3_readdatavalid,
    output logic [out_width-1:0]          pixel,
    output logic                          pixel_valid,
    input  logic                          pixel_ready,
    output logic [$clog2(fifo_depth):0]   fifo_level
);

    localparam int PPW        = 256 / out_width;
    localparam int NUM_WORDS  = num_pixels / PPW;
    localparam int NUM_BURSTS = NUM_WORDS / burst_len;
    localparam int LW         = $clog2(fifo_depth) + 1;
    localparam int PW         = $clog2(fifo_depth);
    localparam int LANE_W     = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int BW         = $clog2(NUM_BURSTS + 1);
    localparam logic [26:0] START_WORD = start_address[31:5];

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_SPACE = 2'd1;
    localparam logic [1:0] ST_READ       = 2'd2;
    localparam logic [1:0] ST_DRAIN      = 2'd3;

    logic [1:0]        state;
    logic [LW-1:0]     outstanding;
    logic [LW-1:0]     cnt;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [255:0]      mem [fifo_depth];
    logic [255:0]      word;
    logic [LANE_W-1:0] lane;
    logic [BW-1:0]     burst_cnt;

    logic rd_accept;
    logic rd_dec;
    logic wr_en;
    logic px_accept;
    logic last_lane;
    logic word_done;
    logic pop;
    logic last_burst;
    logic space_ok;

    assign ddr3_read       = (state == ST_READ);
    assign busy            = (state != ST_IDLE);
    assign ddr3_burstcount = 8'(burst_len);
    assign pixel           = word[lane*out_width +: out_width];
    // Level counts every word not yet fully emitted, including the one in the unpacker.
    assign fifo_level      = cnt + LW'(pixel_valid);

    assign rd_accept  = ddr3_read & ~ddr3_waitrequest;
    assign rd_dec     = ddr3_readdatavalid & (outstanding != '0);
    assign wr_en      = ddr3_readdatavalid & (state != ST_IDLE);
    assign px_accept  = pixel_valid & pixel_ready;
    assign last_lane  = (lane == LANE_W'(PPW - 1));
    assign word_done  = px_accept & last_lane;
    assign pop        = (~pixel_valid | word_done) & (cnt != '0);
    assign last_burst = (burst_cnt == BW'(NUM_BURSTS - 1));
    assign space_ok   = ({1'b0, fifo_level} + {1'b0, outstanding}) <= (LW+1)'(fifo_depth - burst_len);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(fifo_depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge ddr3_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= ddr3_readdata;
        end
    end

    always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
        if (!ddr3_clk_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // A word is refilled on the same edge its last lane is taken, so lanes stream without a bubble.
    always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
        if (!ddr3_clk_reset_n) begin
            word        <= '0;
            lane        <= '0;
            pixel_valid <= 1'b0;
        end else if (pop) begin
            word        <= mem[rd_ptr];
            lane        <= '0;
            pixel_valid <= 1'b1;
        end else if (word_done) begin
            lane        <= '0;
            pixel_valid <= 1'b0;
        end else if (px_accept) begin
            lane        <= lane + 1'b1;
        end
    end

    always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
        if (!ddr3_clk_reset_n) begin
            outstanding <= '0;
        end else begin
            case ({rd_accept, rd_dec})
                2'b10:   outstanding <= outstanding + LW'(burst_len);
                2'b01:   outstanding <= outstanding - 1'b1;
                2'b11:   outstanding <= outstanding + LW'(burst_len - 1);
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef DDR3_READER_LOOP_EN
    localparam int WW = $clog2(NUM_WORDS + 1);
    logic [WW-1:0] word_cnt;
`endif

    always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
        if (!ddr3_clk_reset_n) begin
            state             <= ST_IDLE;
            ddr3_read_address <= '0;
            burst_cnt         <= '0;
            frame_done        <= 1'b0;
`ifdef DDR3_READER_LOOP_EN
            word_cnt          <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ddr3_read_address <= START_WORD;
                        burst_cnt         <= '0;
                        state             <= ST_WAIT_SPACE;
                    end
                end
                ST_WAIT_SPACE: begin
                    if (space_ok) state <= ST_READ;
                end
                ST_READ: begin
                    if (!ddr3_waitrequest) begin
                        ddr3_read_address <= ddr3_read_address + 27'(burst_len);
                        burst_cnt         <= burst_cnt + 1'b1;
                        state             <= ST_WAIT_SPACE;
                        if (last_burst) begin
`ifdef DDR3_READER_LOOP_EN
                            ddr3_read_address <= START_WORD;
                            burst_cnt         <= '0;
`else
                            state             <= ST_DRAIN;
`endif
                        end
                    end
                end
                ST_DRAIN: begin
                    if (outstanding == '0 && cnt == '0 && word_done) begin
                        frame_done <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
`ifdef DDR3_READER_LOOP_EN
            // Words of the next frame may already be queued, so frames are delimited by words emitted.
            if (word_done) begin
                if (word_cnt == WW'(NUM_WORDS - 1)) begin
                    word_cnt   <= '0;
                    frame_done <= 1'b1;
                end else begin
                    word_cnt   <= word_cnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_ddr3_pixel_reader.sv
// Directed bench for ddr3_pixel_reader: 16-bit pixels, 2 bursts of 8 words per 256-pixel frame, scoreboarded output.
module tb_ddr3_pixel_reader;

    localparam logic [26:0] BASE = 27'h1B00000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         busy;
    logic         frame_done;
    logic [26:0]  ddr3_read_address;
    logic         ddr3_read;
    logic [7:0]   ddr3_burstcount;
    logic         ddr3_waitrequest;
    logic [255:0] ddr3_readdata;
    logic         ddr3_readdatavalid;
    logic [15:0]  pixel;
    logic         pixel_valid;
    logic         pixel_ready;
    logic [5:0]   fifo_level;

    ddr3_pixel_reader #(
        .out_width(16), .burst_len(8), .num_pixels(256), .fifo_depth(32), .start_address(32'h36000000)
    ) dut (
        .ddr3_clk(clk), .ddr3_clk_reset_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
        .ddr3_read_address(ddr3_read_address), .ddr3_read(ddr3_read), .ddr3_burstcount(ddr3_burstcount),
        .ddr3_waitrequest(ddr3_waitrequest), .ddr3_readdata(ddr3_readdata),
        .ddr3_readdatavalid(ddr3_readdatavalid), .pixel(pixel), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [26:0] word_q[$];
    logic [15:0] exp_q[$];
    logic [26:0] addr_log[$];
    int          frames = 0;
    int          pix_cnt = 0;
    int          max_level = 0;
    int          cyc = 0;
    int          first_rdv = -1;
    int          first_pv = -1;
    int          pat = 0;
    logic        prev_stall = 1'b0;
    logic [26:0] prev_addr = '0;
    logic        prev_hold = 1'b0;
    logic [15:0] prev_pix = '0;

    // Monitor, scoreboard and zero-wait memory model, all sampled on the falling edge.
    always @(negedge clk) begin
        logic [26:0] idx;
        logic [15:0] val;
        cyc++;
        if (!rst_n) begin
            word_q.delete();
            exp_q.delete();
            ddr3_readdatavalid = 1'b0;
            prev_stall = 1'b0;
            prev_hold  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("read_held", ddr3_read, 1'b1);
                check("addr_held", ddr3_read_address, prev_addr);
            end
            if (prev_hold) begin
                check("valid_held", pixel_valid, 1'b1);
                check("pixel_held", pixel, prev_pix);
            end
            if (frame_done) begin
                frames++;
                check("frame_pixels", pix_cnt, 256);
                pix_cnt = 0;
            end
            if (pixel_valid && first_pv < 0) first_pv = cyc;
            if (pixel_valid && pixel_ready) begin
                if (exp_q.size() == 0) check("pixel_unexpected", pixel_valid, 1'b0);
                else check("pixel", pixel, exp_q.pop_front());
                pix_cnt++;
            end
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            prev_stall = ddr3_read && ddr3_waitrequest;
            prev_addr  = ddr3_read_address;
            prev_hold  = pixel_valid && !pixel_ready;
            prev_pix   = pixel;
            if (word_q.size() > 0) begin
                idx = word_q.pop_front();
                for (int k = 0; k < 16; k++) begin
                    val = (pat == 0) ? idx[15:0] : {idx[11:0], 4'(k)};
                    ddr3_readdata[k*16 +: 16] = val;
                    exp_q.push_back(val);
                end
                ddr3_readdatavalid = 1'b1;
                if (first_rdv < 0) first_rdv = cyc;
            end else begin
                ddr3_readdatavalid = 1'b0;
            end
            if (ddr3_read && !ddr3_waitrequest) begin
                addr_log.push_back(ddr3_read_address);
                for (int i = 0; i < 8; i++) word_q.push_back(ddr3_read_address - BASE + 27'(i));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic new_test(input int p);
        addr_log.delete();
        frames = 0; pix_cnt = 0; max_level = 0; first_rdv = -1; first_pv = -1; pat = p;
    endtask

    task automatic wait_frames(input int target, input int budget, input string tag);
        int k = 0;
        while (frames < target && k < budget) begin
            tick();
            k++;
        end
        check(tag, frames, target);
    endtask

    task automatic check_two_bursts(input string tag);
        check({tag, "_bursts"}, addr_log.size(), 2);
        if (addr_log.size() >= 2) begin
            check({tag, "_addr0"}, addr_log[0], BASE);
            check({tag, "_addr1"}, addr_log[1], BASE + 27'd8);
        end
    endtask

    initial begin
        int k;
        rst_n = 1'b1; start = 1'b0; pixel_ready = 1'b0; ddr3_waitrequest = 1'b0;
        ddr3_readdata = '0; ddr3_readdatavalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_read", ddr3_read, 1'b0);
        check("rst_addr", ddr3_read_address, 27'd0);
        check("rst_valid", pixel_valid, 1'b0);
        check("rst_pixel", pixel, 16'd0);
        check("rst_level", fifo_level, 6'd0);
        check("burstcount", ddr3_burstcount, 8'd8);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Basic frame, ramp pattern, second start while busy must be ignored.
        new_test(0);
        pixel_ready = 1'b1;
        pulse_start();
        check("busy_after_start", busy, 1'b1);
        repeat (5) tick();
        pulse_start();
        wait_frames(1, 2000, "a_frame_done");
        repeat (10) tick();
        check_two_bursts("a");
        check("a_single_done", frames, 1);
        check("a_latency", first_pv - first_rdv, 2);
        check("a_idle", busy, 1'b0);
        check("a_level", fifo_level, 6'd0);
        check("a_sb_empty", exp_q.size(), 0);

        // First read stalled by waitrequest for 5 cycles.
        new_test(1);
        ddr3_waitrequest = 1'b1;
        pulse_start();
        k = 0;
        while (!ddr3_read && k < 20) begin tick(); k++; end
        check("b_read_up", ddr3_read, 1'b1);
        repeat (5) tick();
        check("b_no_accept", addr_log.size(), 0);
        check("b_addr_stall", ddr3_read_address, BASE);
        ddr3_waitrequest = 1'b0;
        wait_frames(1, 2000, "b_frame_done");
        repeat (10) tick();
        check_two_bursts("b");

        // Downstream stalled for 400 cycles: whole frame buffered, then drained losslessly.
        new_test(1);
        pixel_ready = 1'b0;
        pulse_start();
        repeat (400) tick();
        check("c_level_peak", max_level, 16);
        check("c_level_now", fifo_level, 6'd16);
        check("c_busy", busy, 1'b1);
        check_two_bursts("c");
        pixel_ready = 1'b1;
        wait_frames(1, 2000, "c_frame_done");
        check("c_peak_bound", max_level <= 32, 1'b1);
        check("c_sb_empty", exp_q.size(), 0);

        // Ready toggling every cycle.
        new_test(1);
        pixel_ready = 1'b0;
        pulse_start();
        k = 0;
        while (frames < 1 && k < 3000) begin
            pixel_ready = ~pixel_ready;
            tick();
            k++;
        end
        check("d_frame_done", frames, 1);
        check("d_sb_empty", exp_q.size(), 0);
        pixel_ready = 1'b1;

        // Reset after the first burst is accepted, then a fresh frame.
        new_test(1);
        pulse_start();
        k = 0;
        while (addr_log.size() < 1 && k < 50) begin tick(); k++; end
        check("e_first_burst", addr_log.size(), 1);
        rst_n = 1'b0;
        #1;
        check("e_busy", busy, 1'b0);
        check("e_read", ddr3_read, 1'b0);
        check("e_addr", ddr3_read_address, 27'd0);
        check("e_valid", pixel_valid, 1'b0);
        check("e_pixel", pixel, 16'd0);
        check("e_level", fifo_level, 6'd0);
        check("e_frame_done", frame_done, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        new_test(1);
        pulse_start();
        wait_frames(1, 2000, "e_frame_done2");
        repeat (10) tick();
        check_two_bursts("e");

`ifdef DDR3_READER_LOOP_EN
        new_test(0);
        pulse_start();
        wait_frames(3, 5000, "loop_frames");
        check("loop_busy", busy, 1'b1);
        check("loop_log_len", addr_log.size() >= 4, 1'b1);
        if (addr_log.size() >= 4) begin
            check("loop_wrap", addr_log[2], BASE);
            check("loop_wrap1", addr_log[3], BASE + 27'd8);
        end
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr3_pixel_reader.md
DDR3_PIXEL_READER -- requirements
Module: ddr3_pixel_reader

Interface
REQ-001 SHALL have parameter out_width, default 16, pixel width in bits; 256 SHALL be an integer multiple of it.
REQ-002 SHALL have parameter burst_len, default 8, words per Avalon read burst.
REQ-003 SHALL have parameter num_pixels, default 2764800, pixels per frame.
REQ-004 SHALL have parameter fifo_depth, default 32, readback FIFO depth in 256-bit words.
REQ-005 SHALL have parameter start_address, default 32'h36000000, byte address of frame base.
REQ-006 ddr3_clk  in  1  sole clock; all logic on its rising edge.
REQ-007 ddr3_clk_reset_n  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  one-cycle frame-read request.
REQ-009 busy  out  1  frame read in progress.
REQ-010 frame_done  out  1  one-cycle pulse when the last frame pixel is accepted.
REQ-011 ddr3_read_address  out  27  256-bit word address.
REQ-012 ddr3_read  out  1  Avalon read request.
REQ-013 ddr3_burstcount  out  8  constant burst_len.
REQ-014 ddr3_waitrequest  in  1  Avalon stall.
REQ-015 ddr3_readdata  in  256  returned word.
REQ-016 ddr3_readdatavalid  in  1  ddr3_readdata valid.
REQ-017 pixel  out  out_width  output pixel.
REQ-018 pixel_valid  out  1  pixel valid.
REQ-019 pixel_ready  in  1  downstream accepts pixel.
REQ-020 fifo_level  out  $clog2(fifo_depth)+1  words in FIFO.

Function
REQ-021 ppw=256/out_width; num_words=num_pixels/ppw; num_bursts=num_words/burst_len; both divisions SHALL be exact.
REQ-022 FSM states SHALL be ST_IDLE, ST_WAIT_SPACE, ST_READ, ST_DRAIN.
REQ-023 ST_IDLE: start=1 -> load address start_address[31:5], clear burst counter, busy=1, go to ST_WAIT_SPACE; start SHALL be ignored in every other state.
REQ-024 ST_WAIT_SPACE: go to ST_READ when fifo_level + outstanding <= fifo_depth - burst_len.
REQ-025 ST_READ: ddr3_read=1; address SHALL stay stable while ddr3_waitrequest=1; on acceptance (read & !waitrequest): outstanding += burst_len, address += burst_len, go to ST_DRAIN if last burst else ST_WAIT_SPACE.
REQ-026 outstanding SHALL decrement by 1 per ddr3_readdatavalid; simultaneous increment and decrement SHALL net (+burst_len-1).
REQ-027 Every ddr3_readdatavalid outside ST_IDLE SHALL write ddr3_readdata into the FIFO; in ST_IDLE it SHALL be dropped.
REQ-028 The unpacker SHALL emit word lanes low bits first: lane k = word[k*out_width +: out_width].
REQ-029 Lane SHALL advance only on pixel_valid & pixel_ready; pixel and pixel_valid SHALL hold while pixel_valid & !pixel_ready.
REQ-030 On acceptance of lane ppw-1, the next FIFO word SHALL be loaded the same cycle if available, with no bubble.
REQ-031 A word written into an empty FIFO with an empty unpacker SHALL appear on pixel two cycles later.
REQ-032 ST_DRAIN: when outstanding=0, FIFO empty and last lane accepted -> frame_done=1 for one cycle, busy=0, go to ST_IDLE.

Reset
REQ-033 Reset assertion SHALL immediately force: state ST_IDLE, busy=0, frame_done=0, ddr3_read=0, pixel_valid=0, pixel=0, ddr3_read_address=0, outstanding=0, lane=0, FIFO empty (fifo_level=0).
REQ-034 Reset mid-frame SHALL abandon the frame; the next start SHALL read from start_address.

Configuration
REQ-035 Macro DDR3_READER_LOOP_EN: when defined, after the last burst is accepted the address SHALL reload to start_address[31:5] and reading SHALL continue without start; busy stays 1; frame_done pulses per frame; ST_DRAIN unused.
REQ-036 Without DDR3_READER_LOOP_EN the block SHALL be one-shot per start as in REQ-023..REQ-032.

Verification (out_width=16, burst_len=8, num_pixels=256, fifo_depth=32: 16 words, 2 bursts)
REQ-037 start, zero-wait memory returning word i = {16{i[15:0]}}, pixel_ready=1 -> 256 pixels valued 0,0..,1,.. (16 each); addresses 27'h1B00000, 27'h1B00008; single frame_done.
REQ-038 waitrequest high 5 cycles during first read -> address/read held stable; no extra burst issued.
REQ-039 pixel_ready=0 for first 400 cycles -> fifo_level peaks at 16, never exceeds 32; no data lost after release.
REQ-040 pixel_ready toggling every cycle -> each pixel presented until accepted; order preserved.
REQ-041 reset asserted after first burst accepted -> all outputs 0 asynchronously; fresh start reads from 27'h1B00000.
REQ-042 LOOP_EN defined, one start -> continuous bursts wrapping to 27'h1B00000 after 27'h1B00008; frame_done every 256 accepted pixels.
